// File: rtl/clock_divider_ctrl.sv
// Programmable integer clock divider with glitch-free ratio-change handshake.
// Ports: clock/reset_n source clock and async active-low reset; div_valid/
//   div_bits/div_ready offer a divisor code D (ratio D+1); div_done pulses
//   when it takes effect; cur_div is the code in use; clock_out is the
//   flopped divided clock; tick pulses in the cycle clock_out rises.
// Optional: define CLOCK_DIVIDER_STOP_EN to add a `stop` input that parks
//   the divider low at a period boundary.
module clock_divider_ctrl #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 3
) (
  input  logic             clock,
  input  logic             reset_n,
`ifdef CLOCK_DIVIDER_STOP_EN
  input  logic             stop,
`endif
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_bits,
  output logic             div_ready,
  output logic             div_done,
  output logic [WIDTH-1:0] cur_div,
  output logic             clock_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] RST_RAW = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] RST_D =
    (RST_RAW == '0) ? WIDTH'(1) : RST_RAW;

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic             co_d, tick_d, done_d;

  logic             boundary, apply, halt;
  logic [WIDTH-1:0] div_eff;
  logic [WIDTH:0]   r_m1, high;

  always_comb begin
    boundary = (cnt_q == {1'b0, cur_q});
    apply    = boundary && (state_q == PENDING);
    // On the apply cycle the new ratio governs the restarted period.
    div_eff  = apply ? pend_q : cur_q;
    r_m1     = {1'b0, div_eff};
    high     = (r_m1 + 1'b1) >> 1;
`ifdef CLOCK_DIVIDER_STOP_EN
    halt     = boundary && stop;
`else
    halt     = 1'b0;
`endif
    if (halt)
      cnt_d = r_m1;
    else if (boundary)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
    co_d   = !halt && (cnt_d < high);
    tick_d = !halt && (cnt_d == '0);
    done_d = apply;
    cur_d  = div_eff;
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    div_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_ready = 1'b1;
        if (div_valid) begin
          pend_d  = (div_bits == '0) ? WIDTH'(1) : div_bits;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (apply)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= {1'b0, RST_D};
      pend_q    <= RST_D;
      cur_q     <= RST_D;
      clock_out <= 1'b0;
      tick      <= 1'b0;
      div_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      cur_q     <= cur_d;
      clock_out <= co_d;
      tick      <= tick_d;
      div_done  <= done_d;
    end
  end

  assign cur_div = cur_q;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed bench for clock_divider_ctrl.
// Observed bundle per cycle: {clock_out, tick, div_done, div_ready}.
module tb_clock_divider_ctrl;

  logic       clock;
  logic       reset_n;
  logic       div_valid;
  logic [7:0] div_bits;
  logic       div_ready;
  logic       div_done;
  logic [7:0] cur_div;
  logic       clock_out;
  logic       tick;
`ifdef CLOCK_DIVIDER_STOP_EN
  logic       stop;
`endif

  int tests = 0;
  int fails = 0;

  clock_divider_ctrl #(.WIDTH(8), .RESET_DIV(3)) dut (
    .clock(clock),
    .reset_n(reset_n),
`ifdef CLOCK_DIVIDER_STOP_EN
    .stop(stop),
`endif
    .div_valid(div_valid),
    .div_bits(div_bits),
    .div_ready(div_ready),
    .div_done(div_done),
    .cur_div(cur_div),
    .clock_out(clock_out),
    .tick(tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] obs();
    return {clock_out, tick, div_done, div_ready};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    div_valid = 1'b0;
    div_bits  = '0;
`ifdef CLOCK_DIVIDER_STOP_EN
    stop = 1'b0;
`endif
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp [4] = '{4'b1101, 4'b1001, 4'b0001, 4'b0001};
    div_valid = 1'b0;
    div_bits  = '0;
`ifdef CLOCK_DIVIDER_STOP_EN
    stop = 1'b0;
`endif
    reset_n = 1'b0;
    #12;
    tests++;
    if (obs() !== 4'b0001) begin
      fails++;
      $display("FAIL reset_outs got %b want 0001", obs());
    end
    tests++;
    if (cur_div !== 8'd3) begin
      fails++;
      $display("FAIL reset_cur_div got %0d want 3", cur_div);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      tests++;
      if (obs() !== exp[i % 4]) begin
        fails++;
        $display("FAIL reset_run edge %0d got %b want %b",
                 i + 1, obs(), exp[i % 4]);
      end
    end
  endtask

  task automatic test_accept_mid();
    logic [3:0] exp [9] = '{4'b1000, 4'b0000, 4'b0000, 4'b1111,
                            4'b1001, 4'b0001, 4'b0001, 4'b0001,
                            4'b1101};
    reset_dut();
    step();
    div_valid = 1'b1;
    div_bits  = 8'd4;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 0) div_valid = 1'b0;
      tests++;
      if (obs() !== exp[i]) begin
        fails++;
        $display("FAIL accept_mid edge %0d got %b want %b",
                 i + 2, obs(), exp[i]);
      end
      if (i == 2) begin
        tests++;
        if (cur_div !== 8'd3) begin
          fails++;
          $display("FAIL accept_mid_old_div got %0d want 3", cur_div);
        end
      end
    end
    tests++;
    if (cur_div !== 8'd4) begin
      fails++;
      $display("FAIL accept_mid_cur_div got %0d want 4", cur_div);
    end
  endtask

  task automatic test_clamp_zero();
    logic [3:0] exp [10] = '{4'b1100, 4'b1000, 4'b0000, 4'b0000,
                             4'b1111, 4'b0001, 4'b1101, 4'b0001,
                             4'b1101, 4'b0001};
    reset_dut();
    div_valid = 1'b1;
    div_bits  = 8'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) div_valid = 1'b0;
      tests++;
      if (obs() !== exp[i]) begin
        fails++;
        $display("FAIL clamp_zero edge %0d got %b want %b",
                 i + 1, obs(), exp[i]);
      end
    end
    tests++;
    if (cur_div !== 8'd1) begin
      fails++;
      $display("FAIL clamp_zero_cur_div got %0d want 1", cur_div);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp [8] = '{4'b1100, 4'b1000, 4'b0000, 4'b0000,
                            4'b1111, 4'b0001, 4'b0001, 4'b1101};
    reset_dut();
    for (int i = 0; i < 4; i++) step();
    div_valid = 1'b1;
    div_bits  = 8'd2;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) div_bits = 8'd7;
      if (i == 3) div_valid = 1'b0;
      tests++;
      if (obs() !== exp[i]) begin
        fails++;
        $display("FAIL boundary_accept edge %0d got %b want %b",
                 i + 5, obs(), exp[i]);
      end
    end
    tests++;
    if (cur_div !== 8'd2) begin
      fails++;
      $display("FAIL boundary_cur_div got %0d want 2", cur_div);
    end
  endtask

  task automatic test_reset_pending();
    logic [3:0] exp [4] = '{4'b1101, 4'b1001, 4'b0001, 4'b0001};
    reset_dut();
    div_valid = 1'b1;
    div_bits  = 8'd6;
    step();
    div_valid = 1'b0;
    tests++;
    if (div_ready !== 1'b0) begin
      fails++;
      $display("FAIL pend_ready got %b want 0", div_ready);
    end
    step();
    reset_n = 1'b0;
    #1;
    tests++;
    if (obs() !== 4'b0001) begin
      fails++;
      $display("FAIL async_reset got %b want 0001", obs());
    end
    tests++;
    if (cur_div !== 8'd3) begin
      fails++;
      $display("FAIL async_reset_div got %0d want 3", cur_div);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (obs() !== exp[i % 4]) begin
        fails++;
        $display("FAIL post_reset edge %0d got %b want %b",
                 i + 1, obs(), exp[i % 4]);
      end
    end
    tests++;
    if (cur_div !== 8'd3) begin
      fails++;
      $display("FAIL post_reset_div got %0d want 3", cur_div);
    end
  endtask

`ifdef CLOCK_DIVIDER_STOP_EN
  task automatic test_stop();
    logic [3:0] exp [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                            4'b0001, 4'b1101, 4'b1001, 4'b0001};
    reset_dut();
    step();
    step();
    stop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 4) stop = 1'b0;
      tests++;
      if (obs() !== exp[i]) begin
        fails++;
        $display("FAIL stop edge %0d got %b want %b",
                 i + 3, obs(), exp[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_accept_mid();
    test_clamp_zero();
    test_back_to_back();
    test_reset_pending();
`ifdef CLOCK_DIVIDER_STOP_EN
    test_stop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_divider_ctrl.md
Name: clock_divider_ctrl

Overview:
- Programmable integer clock divider with a glitch-free ratio-change handshake.
- Sits directly upstream of the clock-to-data conversion blackbox: its registered `clock_out` is the clock consumed there, and the divided clock is then sampled as an ordinary signal.
- Also produces an aligned one-cycle `tick`, so logic in the source domain can act on divided-clock rising edges without touching the clock net.

Parameters:
- WIDTH, 8, width of the divisor code.
- RESET_DIV, 3, divisor code loaded at reset. The effective ratio is RESET_DIV+1; the default gives divide-by-4.

Ports:
- clock  input  1  source clock; all state is rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- div_valid  input  1  new divisor code offered.
- div_bits  input  WIDTH  divisor code D; ratio R = D+1.
- div_ready  output  1  divider can accept a code.
- div_done  output  1  one-cycle pulse when an accepted code takes effect.
- cur_div  output  WIDTH  divisor code currently in effect.
- clock_out  output  1  divided clock, driven directly from a flop.
- tick  output  1  one-cycle pulse in the cycle `clock_out` rises.

Behaviour:
- Ratio rules
  - R = D+1, computed at WIDTH+1 bits.
  - D=0 is clamped to D=1 (R=2) at acceptance; `cur_div` reports the clamped value.
  - High phase H = R>>1 (floor). R=3 gives 1 high, 2 low; R=4 gives 2 high, 2 low.
- Counter
  - `cnt` is WIDTH+1 bits, range 0..R-1.
  - cnt_next = (cnt==R-1) ? 0 : cnt+1.
  - clock_out <= (cnt_next < H).
  - tick <= (cnt_next == 0).
  - Both outputs are registered. `clock_out` is never produced by combinational logic.
- Period boundary: the cycle where cnt==R-1. `clock_out` is already low there for every R>=2, so a ratio switch at the boundary cannot glitch.
- Handshake state machine
  - IDLE: div_ready=1. When div_valid && div_ready, capture the clamped div_bits into `pend`, go to PENDING.
  - PENDING: div_ready=0. At the first boundary strictly after the acceptance cycle:
    - cur_div <= pend
    - cnt_next = 0, and that cycle's `clock_out`/`tick` use the new R and H
    - div_done <= 1 for one cycle
    - return to IDLE
  - Acceptance in a boundary cycle is not applied at that boundary; it waits one full old period.
  - A new code can be accepted in the cycle `div_done` is high, since the state is already IDLE.
- div_valid while div_ready=0 is ignored. The source must hold its code until accepted.
- Reset values (asynchronous on reset_n low)
  - cnt = RESET_DIV (i.e. R-1)
  - cur_div = RESET_DIV, clamped if 0
  - clock_out=0, tick=0, div_done=0
  - state = IDLE, so div_ready=1 during reset
  - First rising edge after release: cnt_next=0, so clock_out=1 and tick=1.
- Reset mid-operation: a pending code is discarded, outputs return to reset values immediately, and the ratio reverts to RESET_DIV.

Optional Feature:
- Macro: CLOCK_DIVIDER_STOP_EN.
- With the macro defined:
  - Adds input `stop` (1 bit).
  - When stop=1 at a boundary, hold cnt=R-1, clock_out=0, tick=0 in every following cycle while stop remains 1.
  - A pending code still applies at the first stopped boundary cycle, and div_done pulses.
  - When stop drops to 0, the next cycle starts a new period (cnt_next=0, clock_out=1, tick=1).
  - stop asserted mid-period has no effect until the boundary, so a high phase is never truncated.
- Without the macro: no `stop` port, and the divider always runs.

Test Plan:
- Reset release, RESET_DIV=3: clock_out 1,1,0,0 repeating from the first edge; tick high on cycles 1,5,9; div_ready=1; cur_div=3.
- Accept D=4 mid-period: unchanged 4-cycle pattern until the boundary, then clock_out 1,1,0,0,0 repeating; div_done pulses exactly once on the first new high cycle; cur_div=4; div_ready=0 in between.
- Accept D=0: cur_div=1 after apply; clock_out toggles 1,0,1,0; tick every 2 cycles.
- Accept D=2 in a boundary cycle: one full old period of 4 cycles, then 1,0,0 repeating; a second code offered while PENDING gets div_ready=0 and is not captured.
- reset_n low while PENDING with D=6: outputs clear asynchronously; after release the ratio is 4 and div_done never pulses.
- CLOCK_DIVIDER_STOP_EN, RESET_DIV=3, stop=1 raised at cycle 2: the high phase completes and clock_out stays 0 from the boundary on; stop=0 gives clock_out=1 and tick=1 the next cycle.
